// File: rtl/shift_sequencer.sv
// Shift-command sequencer: queues manual shift/clear requests, adds periodic auto steps,
// and hands commands out over a valid/ready port. Optional SHIFT_SEQ_OVF_FLAG_EN builds the sticky ovf flag.
module shift_sequencer #(
    parameter int unsigned TICK_DIV = 1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       left_push,
    input  logic       right_push,
    input  logic       clear_push,
    input  logic       fill_l,
    input  logic       fill_r,
    input  logic       auto_en,
    input  logic       auto_dir,
    input  logic       auto_fill,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [1:0] cmd_op,
    output logic       cmd_bit,
    output logic [2:0] fifo_level,
    output logic       auto_active,
    output logic       ovf
);

    typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_SHL  = 2'b01,
        OP_SHR  = 2'b10,
        OP_CLR  = 2'b11
    } op_t;

    state_t      state_q, state_d;
    op_t         op_q, op_d;
    logic        bit_q, bit_d;
    logic [2:0]  mem_q [4];
    logic [2:0]  mem_d [4];
    logic [1:0]  rd_q, rd_d;
    logic [2:0]  level_q, level_d;
    logic [15:0] tick_q, tick_d;
    logic        pend_q, pend_d;
    logic        act_q;

    logic        do_clr, do_l, do_r, full, empty, pop, serve, wrap;
    logic [1:0]  wr_idx;

    always_comb begin
        do_clr = clear_push;
        do_l   = left_push & ~clear_push;
        do_r   = right_push & ~clear_push & ~left_push;
        full   = (level_q == 3'd4);
        empty  = (level_q == 3'd0);
        wr_idx = rd_q + level_q[1:0];
        // A clear replaces the queue contents this edge, so the old head is not popped.
        pop    = (state_q == IDLE) & ~empty & ~do_clr;
        serve  = (state_q == IDLE) & empty & pend_q & auto_en & ~do_clr;
        wrap   = (tick_q == 16'(TICK_DIV - 1));
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        bit_d   = bit_q;
        mem_d   = mem_q;
        rd_d    = rd_q;
        level_d = level_q;
        tick_d  = '0;
        pend_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = ISSUE;
                    op_d    = op_t'(mem_q[rd_q][2:1]);
                    bit_d   = mem_q[rd_q][0];
                end else if (serve) begin
                    state_d = ISSUE;
                    op_d    = auto_dir ? OP_SHR : OP_SHL;
                    bit_d   = auto_fill;
                end
            end
            ISSUE: begin
                if (cmd_ready) state_d = IDLE;
            end
        endcase

        if (pop) begin
            rd_d    = rd_q + 2'd1;
            level_d = level_q - 3'd1;
        end

        // Fullness is judged before the pop, so a same-edge pop never makes room.
        if (do_clr) begin
            rd_d     = '0;
            level_d  = 3'd1;
            mem_d[0] = {OP_CLR, 1'b0};
        end else if ((do_l | do_r) && !full) begin
            mem_d[wr_idx] = do_l ? {OP_SHL, fill_l} : {OP_SHR, fill_r};
            level_d       = level_d + 3'd1;
        end

        if (auto_en) begin
            tick_d = wrap ? '0 : tick_q + 16'd1;
            pend_d = (pend_q & ~serve) | wrap;
        end
        if (do_clr) pend_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_NONE;
            bit_q   <= 1'b0;
            rd_q    <= '0;
            level_q <= '0;
            tick_q  <= '0;
            pend_q  <= 1'b0;
            act_q   <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) mem_q[i] <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            bit_q   <= bit_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            tick_q  <= tick_d;
            pend_q  <= pend_d;
            act_q   <= auto_en;
            for (int unsigned i = 0; i < 4; i++) mem_q[i] <= mem_d[i];
        end
    end

`ifdef SHIFT_SEQ_OVF_FLAG_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (do_clr) ovf_d = 1'b0;
        else if ((do_l | do_r) && full) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    assign cmd_valid   = (state_q == ISSUE);
    assign cmd_op      = cmd_valid ? op_q : OP_NONE;
    assign cmd_bit     = cmd_valid & bit_q;
    assign fifo_level  = level_q;
    assign auto_active = act_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: queue-based reference model compared every cycle,
// plus directed literal checks for latency, overflow, auto stepping, priority and async reset.
module tb_shift_sequencer;

    localparam int TDIV = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       left_push, right_push, clear_push, fill_l, fill_r;
    logic       auto_en, auto_dir, auto_fill, cmd_ready;
    logic       cmd_valid, cmd_bit, auto_active, ovf;
    logic [1:0] cmd_op;
    logic [2:0] fifo_level;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    shift_sequencer #(.TICK_DIV(TDIV)) dut (
        .clk(clk), .rst_n(rst_n),
        .left_push(left_push), .right_push(right_push), .clear_push(clear_push),
        .fill_l(fill_l), .fill_r(fill_r),
        .auto_en(auto_en), .auto_dir(auto_dir), .auto_fill(auto_fill),
        .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_bit(cmd_bit),
        .fifo_level(fifo_level), .auto_active(auto_active), .ovf(ovf)
    );

    always #5 clk = ~clk;

`ifdef SHIFT_SEQ_OVF_FLAG_EN
    localparam bit OVF_BUILT = 1'b1;
`else
    localparam bit OVF_BUILT = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: command queue plus issue slot and tick bookkeeping.
    logic [2:0] mq[$];
    bit         m_valid, m_bit, m_pend, m_ovf, m_act;
    logic [1:0] m_op;
    int         m_cnt, sz;
    bit         served, wrapped;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_valid = 0; m_op = 2'b00; m_bit = 0;
            m_cnt = 0; m_pend = 0; m_ovf = 0; m_act = 0;
        end else begin
            sz = mq.size();
            served = 0;
            if (m_valid) begin
                if (cmd_ready) m_valid = 0;
            end else if (!clear_push) begin
                if (sz > 0) begin
                    {m_op, m_bit} = mq.pop_front();
                    m_valid = 1;
                end else if (m_pend && auto_en) begin
                    m_op = auto_dir ? 2'b10 : 2'b01;
                    m_bit = auto_fill;
                    m_valid = 1;
                    served = 1;
                end
            end
            if (clear_push) begin
                mq.delete();
                mq.push_back(3'b110);
                m_ovf = 0;
            end else if (left_push || right_push) begin
                if (sz == 4) m_ovf = 1;
                else mq.push_back(left_push ? {2'b01, fill_l} : {2'b10, fill_r});
            end
            if (!auto_en) begin
                m_cnt = 0;
                m_pend = 0;
            end else begin
                wrapped = (m_cnt == TDIV - 1);
                m_cnt = wrapped ? 0 : m_cnt + 1;
                if (served) m_pend = 0;
                if (wrapped) m_pend = 1;
            end
            if (clear_push) m_pend = 0;
            m_act = auto_en;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_cmp",
                  {24'd0, cmd_valid, cmd_op, cmd_bit, fifo_level, auto_active},
                  {24'd0, m_valid, (m_valid ? m_op : 2'b00), (m_valid & m_bit),
                   3'(mq.size()), m_act});
            check("model_ovf", {31'd0, ovf}, {31'd0, m_ovf & OVF_BUILT});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        left_push = 0; right_push = 0; clear_push = 0;
        fill_l = 0; fill_r = 0;
    endtask

    int cnt, idx;
    logic [1:0] ops[$];

    initial begin
        rst_n = 0;
        idle_inputs();
        auto_en = 0; auto_dir = 0; auto_fill = 0; cmd_ready = 1;
        cmp_en = 1;
        repeat (2) cyc();
        check("reset_valid", {31'd0, cmd_valid}, 32'd0);
        check("reset_level", {29'd0, fifo_level}, 32'd0);
        rst_n = 1;
        repeat (2) cyc();

        // Single push: command appears two cycles later, for one cycle.
        left_push = 1; fill_l = 1;
        cyc();
        idle_inputs();
        check("lat_n1_valid", {31'd0, cmd_valid}, 32'd0);
        cyc();
        check("lat_n2", {29'd0, cmd_valid, cmd_op, cmd_bit}, {29'd0, 1'b1, 2'b01, 1'b1});
        cyc();
        check("lat_n3_valid", {31'd0, cmd_valid}, 32'd0);
        repeat (2) cyc();

        // Overflow: FSM busy, five pushes into the queue.
        cmd_ready = 0;
        right_push = 1; fill_r = 0;
        cyc();
        idle_inputs();
        repeat (2) cyc();
        for (int i = 0; i < 5; i++) begin
            left_push = 1; fill_l = i[0];
            cyc();
        end
        idle_inputs();
        check("ovf_level", {29'd0, fifo_level}, 32'd4);
        check("ovf_flag", {31'd0, ovf}, {31'd0, OVF_BUILT});
        cmd_ready = 1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_valid && cmd_op == 2'b01) cnt++;
            cyc();
        end
        check("ovf_shl_count", cnt, 32'd4);
        repeat (2) cyc();

        // Auto stepping with TICK_DIV=4, direction right.
        auto_dir = 1; auto_fill = 1; auto_en = 1;
        cnt = 0; idx = -1;
        for (int i = 0; i < 20; i++) begin
            if (cmd_valid) begin
                cnt++;
                if (idx >= 0) check("auto_period", i - idx, 32'd4);
                else check("auto_first", i, 32'd5);
                idx = i;
                check("auto_op", {30'd0, cmd_op}, 32'd2);
            end
            cyc();
        end
        check("auto_count", cnt, 32'd4);
        auto_en = 0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (cmd_valid) cnt++;
        end
        check("auto_stop", cnt, 32'd0);

        // Simultaneous pushes with three queued entries.
        cmd_ready = 0;
        right_push = 1; fill_r = 1;
        cyc();
        idle_inputs();
        repeat (2) cyc();
        for (int i = 0; i < 3; i++) begin
            left_push = 1; fill_l = 1;
            cyc();
        end
        left_push = 1; right_push = 1; clear_push = 1;
        cyc();
        idle_inputs();
        check("prio_level", {29'd0, fifo_level}, 32'd1);
        check("prio_inflight", {30'd0, cmd_op}, 32'd2);
        cmd_ready = 1;
        ops.delete();
        for (int i = 0; i < 10; i++) begin
            if (cmd_valid) ops.push_back(cmd_op);
            cyc();
        end
        check("prio_ncmds", ops.size(), 32'd2);
        if (ops.size() >= 2) check("prio_clr_next", {30'd0, ops[1]}, 32'd3);
        else check("prio_clr_next", 32'd0, 32'd3);

        // Async reset in the middle of a stalled handshake.
        cmd_ready = 0;
        left_push = 1;
        cyc();
        left_push = 1;
        cyc();
        left_push = 1;
        cyc();
        idle_inputs();
        check("pre_rst_valid", {31'd0, cmd_valid}, 32'd1);
        #1 rst_n = 0;
        #1;
        check("async_rst_valid", {31'd0, cmd_valid}, 32'd0);
        check("async_rst_level", {29'd0, fifo_level}, 32'd0);
        cyc();
        rst_n = 1;
        cmd_ready = 1;
        repeat (2) cyc();

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            left_push  = ($urandom_range(0, 3) == 0);
            right_push = ($urandom_range(0, 3) == 0);
            clear_push = ($urandom_range(0, 31) == 0);
            fill_l     = $urandom_range(0, 1);
            fill_r     = $urandom_range(0, 1);
            cmd_ready  = ($urandom_range(0, 2) != 0);
            auto_dir   = $urandom_range(0, 1);
            auto_fill  = $urandom_range(0, 1);
            if ($urandom_range(0, 49) == 0) auto_en = ~auto_en;
            cyc();
        end
        idle_inputs();
        repeat (3) cyc();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 Parameter TICK_DIV, default 1000, is the number of clk cycles between automatic steps; legal values are 2 to 65535.
REQ-002 clk  in  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 left_push  in  1  single-cycle manual shift-left request pulse.
REQ-005 right_push  in  1  single-cycle manual shift-right request pulse.
REQ-006 clear_push  in  1  single-cycle manual clear request pulse.
REQ-007 fill_l  in  1  serial bit entered at the LSB on a manual shift-left.
REQ-008 fill_r  in  1  serial bit entered at the MSB on a manual shift-right.
REQ-009 auto_en  in  1  level input; 1 enables automatic stepping.
REQ-010 auto_dir  in  1  automatic step direction: 0 = shift left, 1 = shift right.
REQ-011 auto_fill  in  1  serial bit used for automatic steps.
REQ-012 cmd_ready  in  1  datapath accepts the current command.
REQ-013 cmd_valid  out  1  command present on cmd_op and cmd_bit.
REQ-014 cmd_op  out  2  command opcode: 01 = SHL, 10 = SHR, 11 = CLR; 00 when idle.
REQ-015 cmd_bit  out  1  serial bit for SHL/SHR; 0 for CLR.
REQ-016 fifo_level  out  3  number of queued manual commands, 0 to 4.
REQ-017 auto_active  out  1  registered copy of auto_en.
REQ-018 ovf  out  1  sticky flag: a manual request was dropped because the queue was full.

Function
REQ-019 Manual requests SHALL be queued in a 4-entry FIFO of {op, bit}: left_push writes {SHL, fill_l}; right_push writes {SHR, fill_r}.
REQ-020 Simultaneous pushes in one cycle SHALL be resolved by priority clear > left > right; only the winner is acted on and the losers are discarded without setting ovf.
REQ-021 clear_push SHALL flush the FIFO and write a single {CLR, 0} entry in the same edge, and SHALL clear tick_pending.
REQ-022 A left_push or right_push arriving while the FIFO holds 4 entries SHALL be dropped and SHALL set ovf; a pop in the same cycle does not free space for that write.
REQ-023 While auto_en=1, the tick counter SHALL run 0 to TICK_DIV-1 and wrap; each wrap SHALL set tick_pending. While auto_en=0, the counter and tick_pending SHALL be held at 0.
REQ-024 tick_pending SHALL be sticky until served; further wraps while it is set SHALL be absorbed and not accumulated.
REQ-025 The issue FSM has two states, IDLE (cmd_valid=0) and ISSUE (cmd_valid=1).
REQ-026 IDLE->ISSUE: if the FIFO is non-empty, the FIFO head SHALL be popped into the command register; otherwise, if tick_pending=1, {auto_dir?SHR:SHL, auto_fill} SHALL be loaded and tick_pending cleared.
REQ-027 The FIFO SHALL have priority over an automatic tick, and the tick SHALL remain pending while it waits.
REQ-028 In ISSUE, cmd_op and cmd_bit SHALL be held stable until cmd_valid&cmd_ready; the FSM SHALL return to IDLE on the edge that ends the handshake cycle.
REQ-029 Latency: a push in cycle N that finds the FIFO empty and the FSM in IDLE SHALL produce cmd_valid=1 in cycle N+2; sustained throughput is 1 command per 2 cycles.
REQ-030 A clear_push during ISSUE SHALL NOT alter the in-flight command; the CLR is issued next.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, empty the FIFO, zero the tick counter, and clear tick_pending, ovf and auto_active; cmd_valid=0, cmd_op=00, cmd_bit=0 and fifo_level=0, including mid-handshake.
REQ-032 After rst_n deasserts, the first state change SHALL occur on the following rising clk edge.

Configuration
REQ-033 With the macro SHIFT_SEQ_OVF_FLAG_EN defined, ovf behaves per REQ-022 and is cleared only by reset or clear_push; without the macro, ovf SHALL be tied to 0 and no flag register is built, while drop behaviour is unchanged.

Verification
REQ-034 Single left_push with fill_l=1 and cmd_ready=1 -> cmd_valid=1 with op=01 and bit=1 two cycles later, for one cycle.
REQ-035 cmd_ready=0 while 5 left_push pulses arrive -> fifo_level=4, ovf=1 (macro defined) or 0 (macro undefined), and exactly 4 SHL commands issued once cmd_ready=1.
REQ-036 auto_en=1, TICK_DIV=4, auto_dir=1, cmd_ready=1 -> an SHR command every 4 cycles; setting auto_en=0 stops the commands with no stale tick.
REQ-037 left_push, right_push and clear_push in the same cycle while the FIFO holds 3 entries -> fifo_level=1 and the next command is CLR (op=11).
REQ-038 Assert rst_n=0 mid-ISSUE with cmd_ready=0 -> cmd_valid=0 and fifo_level=0 without waiting for a clk edge.
